// File: rtl/phase_arbiter.sv
// Round-robin arbiter sharing one pipelined phase unit between two requesters.
// In-flight requests are tagged in order so each result returns to its origin.
module phase_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_AW    = 2,
    parameter int TAG_AW     = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] req_i_1,
    input  logic [DATA_WIDTH-1:0] req_q_1,
    input  logic                  req_stb_1,
    input  logic [DATA_WIDTH-1:0] req_i_2,
    input  logic [DATA_WIDTH-1:0] req_q_2,
    input  logic                  req_stb_2,
    output logic [DATA_WIDTH-1:0] phase_in_i,
    output logic [DATA_WIDTH-1:0] phase_in_q,
    output logic                  phase_in_stb,
    input  logic [DATA_WIDTH-1:0] phase_out,
    input  logic                  phase_out_stb,
    output logic [DATA_WIDTH-1:0] phase_out_1,
    output logic                  phase_out_stb_1,
    output logic [DATA_WIDTH-1:0] phase_out_2,
    output logic                  phase_out_stb_2,
    output logic                  overflow_1,
    output logic                  overflow_2,
    output logic                  tag_error
);
    localparam int DW = DATA_WIDTH;
    localparam int FD = 1 << FIFO_AW;
    localparam int TD = 1 << TAG_AW;
    localparam logic [FIFO_AW:0] F_FULL = (FIFO_AW+1)'(FD);
    localparam logic [TAG_AW:0]  T_FULL = (TAG_AW+1)'(TD);

    typedef logic [2*DW-1:0] iq_t;

    iq_t                fifo_q [2][FD];
    logic [FIFO_AW-1:0] rd_q   [2];
    logic [FIFO_AW-1:0] wr_q   [2];
    logic [FIFO_AW:0]   cnt_q  [2];

    logic               tag_q  [TD];
    logic [TAG_AW-1:0]  trd_q;
    logic [TAG_AW-1:0]  twr_q;
    logic [TAG_AW:0]    tcnt_q;
    logic               last2_q;

    logic [1:0] stb;
    logic [1:0] avail;
    logic [1:0] gnt;
    logic [1:0] push;
    logic [1:0] drop;
    iq_t        din  [2];
    iq_t        head [2];
    iq_t        sel;
    logic       tag_full;
    logic       tpop;
    logic       terr;

    // An empty FIFO falls through so a lone request issues the next cycle.
    always_comb begin
        stb     = {req_stb_2, req_stb_1};
        din[0]  = {req_i_1, req_q_1};
        din[1]  = {req_i_2, req_q_2};
        for (int k = 0; k < 2; k++) begin
            avail[k] = (cnt_q[k] != '0) || (enable && stb[k]);
            head[k]  = (cnt_q[k] == '0) ? din[k] : fifo_q[k][rd_q[k]];
        end
        tag_full = (tcnt_q == T_FULL);
        gnt      = 2'b00;
        if (enable && !tag_full) begin
            if (avail[0] && (!avail[1] || last2_q)) begin
                gnt[0] = 1'b1;
            end else if (avail[1]) begin
                gnt[1] = 1'b1;
            end
        end
        for (int k = 0; k < 2; k++) begin
            push[k] = enable && stb[k] && ((cnt_q[k] != F_FULL) || gnt[k]);
            drop[k] = enable && stb[k] && !push[k];
        end
        sel  = gnt[1] ? head[1] : head[0];
        tpop = phase_out_stb && (tcnt_q != '0);
        terr = phase_out_stb && (tcnt_q == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                rd_q[k]  <= '0;
                wr_q[k]  <= '0;
                cnt_q[k] <= '0;
            end
            trd_q           <= '0;
            twr_q           <= '0;
            tcnt_q          <= '0;
            last2_q         <= 1'b1;
            phase_in_i      <= '0;
            phase_in_q      <= '0;
            phase_in_stb    <= 1'b0;
            phase_out_1     <= '0;
            phase_out_2     <= '0;
            phase_out_stb_1 <= 1'b0;
            phase_out_stb_2 <= 1'b0;
            overflow_1      <= 1'b0;
            overflow_2      <= 1'b0;
            tag_error       <= 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (push[k]) wr_q[k] <= wr_q[k] + FIFO_AW'(1);
                if (gnt[k])  rd_q[k] <= rd_q[k] + FIFO_AW'(1);
                if (push[k] && !gnt[k]) begin
                    cnt_q[k] <= cnt_q[k] + (FIFO_AW+1)'(1);
                end else if (!push[k] && gnt[k]) begin
                    cnt_q[k] <= cnt_q[k] - (FIFO_AW+1)'(1);
                end
            end
            if (|gnt) twr_q <= twr_q + TAG_AW'(1);
            if (tpop) trd_q <= trd_q + TAG_AW'(1);
            if ((|gnt) && !tpop) begin
                tcnt_q <= tcnt_q + (TAG_AW+1)'(1);
            end else if (!(|gnt) && tpop) begin
                tcnt_q <= tcnt_q - (TAG_AW+1)'(1);
            end
            if (|gnt) begin
                last2_q    <= gnt[1];
                phase_in_i <= sel[2*DW-1:DW];
                phase_in_q <= sel[DW-1:0];
            end
            phase_in_stb    <= |gnt;
            phase_out_stb_1 <= tpop && !tag_q[trd_q];
            phase_out_stb_2 <= tpop && tag_q[trd_q];
            if (tpop) begin
                phase_out_1 <= phase_out;
                phase_out_2 <= phase_out;
            end
            overflow_1 <= overflow_1 | drop[0];
            overflow_2 <= overflow_2 | drop[1];
            tag_error  <= tag_error | terr;
        end
    end

    always_ff @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (push[k]) fifo_q[k][wr_q[k]] <= din[k];
        end
        if (|gnt) tag_q[twr_q] <= gnt[1];
    end

endmodule

// File: tb/tb_phase_arbiter.sv
// Bench for phase_arbiter: stub phase unit with fixed latency and hold,
// scoreboard queues for issue order and per-antenna routed results.
module tb_phase_arbiter;
    localparam int DW  = 32;
    localparam int LAT = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic [DW-1:0] req_i_1, req_q_1, req_i_2, req_q_2;
    logic          req_stb_1, req_stb_2;
    logic [DW-1:0] phase_in_i, phase_in_q;
    logic          phase_in_stb;
    logic [DW-1:0] phase_out;
    logic          phase_out_stb;
    logic [DW-1:0] phase_out_1, phase_out_2;
    logic          phase_out_stb_1, phase_out_stb_2;
    logic          overflow_1, overflow_2, tag_error;

    always #5 clock = ~clock;

    phase_arbiter #(
        .DATA_WIDTH(DW),
        .FIFO_AW(2),
        .TAG_AW(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .req_i_1(req_i_1),
        .req_q_1(req_q_1),
        .req_stb_1(req_stb_1),
        .req_i_2(req_i_2),
        .req_q_2(req_q_2),
        .req_stb_2(req_stb_2),
        .phase_in_i(phase_in_i),
        .phase_in_q(phase_in_q),
        .phase_in_stb(phase_in_stb),
        .phase_out(phase_out),
        .phase_out_stb(phase_out_stb),
        .phase_out_1(phase_out_1),
        .phase_out_stb_1(phase_out_stb_1),
        .phase_out_2(phase_out_2),
        .phase_out_stb_2(phase_out_stb_2),
        .overflow_1(overflow_1),
        .overflow_2(overflow_2),
        .tag_error(tag_error)
    );

    typedef struct { logic [DW-1:0] i; logic [DW-1:0] q; } iq_t;
    typedef struct { logic [DW-1:0] v; int due; } st_t;

    iq_t           issq[$];
    logic [DW-1:0] exp1q[$];
    logic [DW-1:0] exp2q[$];
    st_t           stubq[$];
    int            iss_cyc[$];
    bit            hold = 1'b0;
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] f(input logic [DW-1:0] i,
                                        input logic [DW-1:0] q);
        return (i + q) ^ 32'h0000_1234;
    endfunction

    always @(posedge clock) cyc++;

    // Stub phase unit: in-order results after LAT cycles, one per cycle.
    always @(posedge clock) begin
        #1;
        phase_out_stb = 1'b0;
        if (!hold && stubq.size() != 0 && cyc >= stubq[0].due) begin
            phase_out     = stubq[0].v;
            phase_out_stb = 1'b1;
            void'(stubq.pop_front());
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            if (phase_in_stb) begin
                iss_cyc.push_back(cyc);
                if (issq.size() == 0) begin
                    chk("unexp_issue", 32'(phase_in_stb), 32'd0);
                end else begin
                    iq_t e;
                    e = issq.pop_front();
                    chk("iss_i", phase_in_i, e.i);
                    chk("iss_q", phase_in_q, e.q);
                end
                stubq.push_back('{f(phase_in_i, phase_in_q), cyc + LAT});
            end
            if (phase_out_stb_1 && phase_out_stb_2)
                chk("both_stb", 32'(phase_out_stb_2), 32'd0);
            if (phase_out_stb_1) begin
                if (exp1q.size() == 0) chk("unexp_out1", 32'(phase_out_stb_1), 32'd0);
                else chk("out1", phase_out_1, exp1q.pop_front());
            end
            if (phase_out_stb_2) begin
                if (exp2q.size() == 0) chk("unexp_out2", 32'(phase_out_stb_2), 32'd0);
                else chk("out2", phase_out_2, exp2q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic flush_sb();
        issq.delete();
        exp1q.delete();
        exp2q.delete();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_stb_1 = 1'b0;
        req_stb_2 = 1'b0;
        enable    = 1'b1;
        hold      = 1'b0;
        step(2);
        reset = 1'b0;
        flush_sb();
        stubq.delete();
    endtask

    task automatic drive(input bit s1, input bit s2,
                         input logic [DW-1:0] i1, input logic [DW-1:0] q1,
                         input logic [DW-1:0] i2, input logic [DW-1:0] q2,
                         input bit e1, input bit e2);
        req_stb_1 = s1; req_i_1 = i1; req_q_1 = q1;
        req_stb_2 = s2; req_i_2 = i2; req_q_2 = q2;
        if (s1 && e1) begin
            issq.push_back('{i1, q1});
            exp1q.push_back(f(i1, q1));
        end
        if (s2 && e2) begin
            issq.push_back('{i2, q2});
            exp2q.push_back(f(i2, q2));
        end
        step(1);
        req_stb_1 = 1'b0;
        req_stb_2 = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((issq.size() != 0 || exp1q.size() != 0 || exp2q.size() != 0 ||
                stubq.size() != 0) && n < 400) begin
            step(1);
            n++;
        end
        chk(tag, 32'(n < 400), 32'd1);
    endtask

    task automatic check_zero(input string p);
        chk({p, "_in_stb"}, 32'(phase_in_stb), 32'd0);
        chk({p, "_in_i"}, phase_in_i, 32'd0);
        chk({p, "_in_q"}, phase_in_q, 32'd0);
        chk({p, "_out1"}, phase_out_1, 32'd0);
        chk({p, "_out2"}, phase_out_2, 32'd0);
        chk({p, "_stb1"}, 32'(phase_out_stb_1), 32'd0);
        chk({p, "_stb2"}, 32'(phase_out_stb_2), 32'd0);
        chk({p, "_ovf1"}, 32'(overflow_1), 32'd0);
        chk({p, "_ovf2"}, 32'(overflow_2), 32'd0);
        chk({p, "_tagerr"}, 32'(tag_error), 32'd0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1;
        req_i_1 = '0; req_q_1 = '0; req_stb_1 = 1'b0;
        req_i_2 = '0; req_q_2 = '0; req_stb_2 = 1'b0;
        phase_out = '0; phase_out_stb = 1'b0;
        step(1);

        // 1: single antenna-1 request
        do_reset();
        check_zero("rst");
        drive(1, 0, 32'd100, 32'hFFFF_FFCE, '0, '0, 1, 0);
        chk("lat1", 32'(phase_in_stb), 32'd1);
        wait_drain("t1_drain");

        // 2: both antennas, 4 cycles, alternate issue order
        do_reset();
        for (int c = 0; c < 4; c++)
            drive(1, 1, $urandom, $urandom, $urandom, $urandom, 1, 1);
        wait_drain("t2_drain");
        chk("t2_ovf1", 32'(overflow_1), 32'd0);
        chk("t2_ovf2", 32'(overflow_2), 32'd0);

        // 3: tag FIFO full, input FIFO fills, 5th request dropped
        do_reset();
        hold = 1'b1;
        for (int c = 0; c < 4; c++)
            drive(1, 0, $urandom, $urandom, '0, '0, 1, 0);
        for (int c = 0; c < 5; c++)
            drive(1, 0, $urandom, $urandom, '0, '0, c < 4, 0);
        step(1);
        chk("t3_ovf1", 32'(overflow_1), 32'd1);
        chk("t3_ovf2", 32'(overflow_2), 32'd0);
        hold = 1'b0;
        wait_drain("t3_drain");
        chk("t3_ovf1_sticky", 32'(overflow_1), 32'd1);

        // 6: enable low holds buffered requests; in-flight results still return
        do_reset();
        hold = 1'b1;
        for (int c = 0; c < 4; c++)
            drive(1, 0, $urandom, $urandom, '0, '0, 1, 0);
        for (int c = 0; c < 2; c++)
            drive(0, 1, '0, '0, $urandom, $urandom, 0, 1);
        step(1);
        enable = 1'b0;
        hold   = 1'b0;
        iss_cyc.delete();
        step(16);
        chk("t6_noissue", iss_cyc.size(), 32'd0);
        chk("t6_ret1", exp1q.size(), 32'd0);
        enable = 1'b1;
        step(4);
        chk("t6_issues", iss_cyc.size(), 32'd2);
        if (iss_cyc.size() == 2)
            chk("t6_consec", iss_cyc[1] - iss_cyc[0], 32'd1);
        wait_drain("t6_drain");

        // 4: spurious result
        do_reset();
        stubq.push_back('{32'hDEAD_BEEF, cyc});
        step(3);
        chk("t4_tagerr", 32'(tag_error), 32'd1);
        step(3);
        chk("t4_sticky", 32'(tag_error), 32'd1);
        do_reset();
        chk("t4_clr", 32'(tag_error), 32'd0);

        // 5: reset with 3 requests in flight
        for (int c = 0; c < 3; c++)
            drive(1, 0, $urandom, $urandom, '0, '0, 1, 0);
        step(2);
        chk("t5_inflight", stubq.size(), 32'd3);
        reset = 1'b1;
        flush_sb();
        step(1);
        check_zero("t5_rst");
        reset = 1'b0;
        wait_drain("t5_drain");
        step(2);
        chk("t5_tagerr", 32'(tag_error), 32'd1);
        chk("t5_nostb1", 32'(phase_out_stb_1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
